// File: rtl/info_stream_buffer.sv
// info_stream_buffer: message buffer in front of the QPSK symbol mapper.
// Words are stored in a simple-dual-port RAM and replayed on a valid/ready
// read stream, either once (FIFO mode) or cyclically (LOOP mode).
//
// Handshake rule for both streams: a beat moves on a rising edge where the
// producer's valid and the consumer's ready are both high. A producer never
// withdraws or changes a presented beat while ready is low.
module info_stream_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_EXP   = 10,
  parameter int OUT_REG    = 1
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_mode,
  input  logic [ADDR_EXP:0]     i_loop_len,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic [ADDR_EXP:0]     o_count,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_wrap,
  output logic [1:0]            o_dbg_state
);

  localparam int DEPTH  = 2 ** ADDR_EXP;
  localparam int QDEPTH = OUT_REG + 2;
  localparam int QW     = $clog2(QDEPTH + 1);
  localparam int QI     = $clog2(QDEPTH);
  localparam logic [ADDR_EXP:0] FULL_CNT = {1'b1, {ADDR_EXP{1'b0}}};
  localparam logic [QW-1:0]     QDEPTH_L = QW'(QDEPTH);
  localparam logic [QI-1:0]     QLAST_L  = QI'(QDEPTH - 1);

  typedef enum logic [1:0] {
    RUN_FIFO = 2'd0,
    RUN_LOOP = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_mode;
  logic [ADDR_EXP-1:0]     r_wr_ptr;
  logic [ADDR_EXP-1:0]     r_rd_ptr;
  logic [ADDR_EXP-1:0]     r_loop_idx;
  logic [ADDR_EXP:0]       r_count;
  logic [ADDR_EXP:0]       r_loop_len;
  // issued reads not yet transferred: RAM pipeline plus prefetch queue
  logic [QW-1:0]           r_out_cnt;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]   r_ram_q;
  logic                    r_s0_vld;
  logic                    r_s0_last;

  logic [DATA_WIDTH-1:0]   r_q_dat [QDEPTH];
  logic [QDEPTH-1:0]       r_q_last;
  logic [QI-1:0]           r_q_wr;
  logic [QI-1:0]           r_q_rd;
  logic [QW-1:0]           r_q_cnt;

  logic                    w_change;
  logic                    w_wr_fire;
  logic                    w_pop;
  logic                    w_fifo_pop;
  logic                    w_credit;
  logic                    w_unissued;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_loop_last;
  logic [ADDR_EXP-1:0]     w_raddr;
  logic [ADDR_EXP-1:0]     w_rewind;
  logic                    w_pipe_vld;
  logic                    w_pipe_last;
  logic [DATA_WIDTH-1:0]   w_pipe_dat;
  logic                    w_push;

  function automatic logic [QI-1:0] q_inc(input logic [QI-1:0] p);
    return (p == QLAST_L) ? '0 : p + 1'b1;
  endfunction

  // Handshake, occupancy flags and read-issue decision
  always_comb begin
    w_change     = (r_state != FLUSH) && (i_mode != r_mode);
    o_full       = (r_count == FULL_CNT);
    o_empty      = (r_count == '0);
    o_count      = r_count;
    o_wr_ready   = !r_mode && !o_full;
    w_wr_fire    = i_wr_valid && o_wr_ready;
    o_rd_valid   = (r_q_cnt != '0);
    o_rd_data    = o_rd_valid ? r_q_dat[r_q_rd] : '0;
    w_pop        = o_rd_valid && i_rd_ready;
    w_fifo_pop   = w_pop && !r_mode;
    o_wrap       = w_pop && r_q_last[r_q_rd];
    o_dbg_state  = r_state;
    // a transfer in this cycle frees its slot, so streaming has no bubbles
    w_credit     = (r_out_cnt < QDEPTH_L) || w_pop;
    // full and empty both have rd_ptr == wr_ptr, so use the counts instead
    w_unissued   = (r_count != (ADDR_EXP + 1)'(r_out_cnt));
    w_loop_last  = ({1'b0, r_loop_idx} == (r_loop_len - 1'b1));
    w_issue      = !w_change && w_credit &&
                   (((r_state == RUN_FIFO) && w_unissued) ||
                    ((r_state == RUN_LOOP) && (r_loop_len != '0)));
    w_issue_last = (r_state == RUN_LOOP) && w_loop_last;
    w_raddr      = (r_state == RUN_LOOP) ? r_loop_idx : r_rd_ptr;
    // flushed FIFO words that were not transferred must be read again
    w_rewind     = ADDR_EXP'(r_out_cnt - QW'(w_pop));
    w_push       = w_pipe_vld && !w_change;
  end

  // Next-state logic: any mode change passes through one FLUSH cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN_FIFO, RUN_LOOP: if (w_change) w_state_nxt = FLUSH;
      FLUSH:              w_state_nxt = r_mode ? RUN_LOOP : RUN_FIFO;
      default:            w_state_nxt = RUN_FIFO;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (i_rst) r_state <= RUN_FIFO;
    else       r_state <= w_state_nxt;
  end

  // Mode, pointers, occupancy and outstanding-read bookkeeping
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_mode     <= 1'b0;
      r_loop_len <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_loop_idx <= '0;
      r_count    <= '0;
      r_out_cnt  <= '0;
    end else begin
      if (w_change) begin
        r_mode <= i_mode;
        if (i_mode) r_loop_len <= i_loop_len;
      end
      if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      case ({w_wr_fire, w_fifo_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_change && !r_mode)
        r_rd_ptr <= r_rd_ptr - w_rewind;
      else if (w_issue && (r_state == RUN_FIFO))
        r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_change)
        r_loop_idx <= '0;
      else if (w_issue && (r_state == RUN_LOOP))
        r_loop_idx <= w_loop_last ? '0 : r_loop_idx + 1'b1;
      if (w_change) r_out_cnt <= '0;
      else          r_out_cnt <= r_out_cnt + QW'(w_issue) - QW'(w_pop);
    end
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // RAM read port (first read stage, no reset so it maps to block RAM)
  always_ff @(posedge clk) begin
    if (w_issue) r_ram_q <= r_mem[w_raddr];
  end

  // Valid and wrap tag travelling alongside the RAM read
  always_ff @(posedge clk) begin
    if (i_rst || w_change) begin
      r_s0_vld  <= 1'b0;
      r_s0_last <= 1'b0;
    end else begin
      r_s0_vld  <= w_issue;
      r_s0_last <= w_issue_last;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s1_vld;
      logic                  r_s1_last;
      logic [DATA_WIDTH-1:0] r_s1_dat;
      // Extra RAM output register stage
      always_ff @(posedge clk) begin
        if (i_rst || w_change) begin
          r_s1_vld  <= 1'b0;
          r_s1_last <= 1'b0;
        end else begin
          r_s1_vld  <= r_s0_vld;
          r_s1_last <= r_s0_last;
        end
        r_s1_dat <= r_ram_q;
      end
      assign w_pipe_vld  = r_s1_vld;
      assign w_pipe_last = r_s1_last;
      assign w_pipe_dat  = r_s1_dat;
    end else begin : g_no_out_reg
      assign w_pipe_vld  = r_s0_vld;
      assign w_pipe_last = r_s0_last;
      assign w_pipe_dat  = r_ram_q;
    end
  endgenerate

  // Prefetch queue pointers and fill level
  always_ff @(posedge clk) begin
    if (i_rst || w_change) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_push) r_q_wr <= q_inc(r_q_wr);
      if (w_pop)  r_q_rd <= q_inc(r_q_rd);
      r_q_cnt <= r_q_cnt + QW'(w_push) - QW'(w_pop);
    end
  end

  // Prefetch queue storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_dat[r_q_wr]  <= w_pipe_dat;
      r_q_last[r_q_wr] <= w_pipe_last;
    end
  end

endmodule

// File: tb/tb_info_stream_buffer.sv
// Bench for info_stream_buffer (DEPTH 8, extra RAM output register).
module tb_info_stream_buffer;
  localparam int DW = 32;
  localparam int AE = 3;
  localparam int OR = 1;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_mode = 1'b0;
  logic [AE:0]   i_loop_len = '0;
  logic          i_wr_valid = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          o_wr_ready;
  logic          o_rd_valid;
  logic [DW-1:0] o_rd_data;
  logic          i_rd_ready = 1'b0;
  logic [AE:0]   o_count;
  logic          o_full;
  logic          o_empty;
  logic          o_wrap;
  logic [1:0]    o_dbg_state;

  info_stream_buffer #(.DATA_WIDTH(DW), .ADDR_EXP(AE), .OUT_REG(OR)) dut (
    .clk(clk), .i_rst(i_rst), .i_mode(i_mode), .i_loop_len(i_loop_len),
    .i_wr_valid(i_wr_valid), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_wrap(o_wrap),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  int  n_total = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  bit  loop_flag = 1'b0;
  bit  stall_prev = 1'b0;
  logic [DW-1:0] held = '0;
  int  n_xfer = 0;
  int  run_len = 0;
  int  max_run = 0;
  int  first_vld_cyc = -1;
  int  last_acc_cyc = 0;
  bit  wr_done = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit do_push);
    int g = 0;
    i_wr_valid = 1'b1;
    i_wr_data  = d;
    while (!o_wr_ready && g < 2000) begin
      step();
      g++;
    end
    if (o_wr_ready) begin
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      if (do_push) exp_q.push_back(d);
    end else begin
      check_eq("wr_timeout", 32'(o_wr_ready), 32'd1);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 3000) begin
      step();
      g++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: compare each read transfer against the expected queue
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (chk_en) begin
      if (stall_prev) begin
        check_eq("stall_vld", 32'(o_rd_valid), 32'd1);
        check_eq("stall_data", o_rd_data, held);
      end
      stall_prev = o_rd_valid && !i_rd_ready;
      held = o_rd_data;
      if (o_rd_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (o_rd_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (o_rd_valid && i_rd_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          check_eq("extra_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("rd_data", o_rd_data, e);
          check_eq("wrap", 32'(o_wrap), 32'(loop_flag && (e == 32'hA4)));
        end
      end
    end else begin
      stall_prev = 1'b0;
      run_len = 0;
    end
  end

  initial begin
    int tgt;
    int g;
    logic [DW-1:0] loop_vals[5];

    // reset values
    repeat (2) step();
    check_eq("rst_vld", 32'(o_rd_valid), 32'd0);
    check_eq("rst_cnt", 32'(o_count), 32'd0);
    check_eq("rst_empty", 32'(o_empty), 32'd1);
    check_eq("rst_full", 32'(o_full), 32'd0);
    check_eq("rst_wrap", 32'(o_wrap), 32'd0);
    check_eq("rst_data", o_rd_data, 32'd0);
    i_rst = 1'b0;
    step();
    check_eq("rst_wr_rdy", 32'(o_wr_ready), 32'd1);

    // streaming: 1..8 back-to-back with consumer always ready
    chk_en = 1'b1;
    i_rd_ready = 1'b1;
    max_run = 0;
    first_vld_cyc = -1;
    wr(32'h1, 1'b1);
    tgt = last_acc_cyc;
    for (int i = 2; i <= 8; i++) wr(32'(i), 1'b1);
    wait_drain("drain_stream");
    check_eq("first_latency", 32'(first_vld_cyc - tgt), 32'd3);
    check_eq("burst_len", 32'(max_run), 32'd8);

    // full boundary and pointer wrap
    i_rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(32'h10 + 32'(i), 1'b1);
    check_eq("full_flag", 32'(o_full), 32'd1);
    check_eq("full_wr_rdy", 32'(o_wr_ready), 32'd0);
    check_eq("full_cnt", 32'(o_count), 32'd8);
    i_rd_ready = 1'b1;
    tgt = n_xfer + 3;
    check_eq("full_rdy_hold", 32'(o_wr_ready), 32'd0);
    step();
    check_eq("full_rdy_rise", 32'(o_wr_ready), 32'd1);
    g = 0;
    while (n_xfer < tgt && g < 100) begin
      step();
      g++;
    end
    i_rd_ready = 1'b0;
    check_eq("cnt_after3", 32'(o_count), 32'd5);
    for (int i = 0; i < 3; i++) wr(32'h18 + 32'(i), 1'b1);
    check_eq("refill_cnt", 32'(o_count), 32'd8);
    check_eq("refill_full", 32'(o_full), 32'd1);
    i_rd_ready = 1'b1;
    wait_drain("drain_full");
    check_eq("drained_empty", 32'(o_empty), 32'd1);

    // random backpressure over 100 words
    wr_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          wr($urandom, 1'b1);
          if ($urandom_range(0, 3) == 0) step();
        end
        wr_done = 1'b1;
      end
      begin
        g = 0;
        while (!(wr_done && exp_q.size() == 0) && g < 20000) begin
          i_rd_ready = 1'($urandom_range(0, 1));
          step();
          g++;
        end
      end
    join
    check_eq("bp_left", 32'(exp_q.size()), 32'd0);
    check_eq("bp_cnt", 32'(o_count), 32'd0);

    // reset in the middle of a stream
    i_rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(32'h30 + 32'(i), 1'b1);
    repeat (3) step();
    i_rd_ready = 1'b1;
    repeat (2) step();
    chk_en = 1'b0;
    i_rd_ready = 1'b0;
    i_rst = 1'b1;
    step();
    check_eq("mid_rst_vld", 32'(o_rd_valid), 32'd0);
    check_eq("mid_rst_cnt", 32'(o_count), 32'd0);
    check_eq("mid_rst_empty", 32'(o_empty), 32'd1);
    check_eq("mid_rst_data", o_rd_data, 32'd0);
    i_rst = 1'b0;
    exp_q.delete();
    step();
    chk_en = 1'b1;

    // LOOP replay and mode switch while FIFO words sit in the queue
    loop_vals = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int i = 0; i < 6; i++) wr(32'hA0 + 32'(i), 1'b0);
    repeat (5) step();
    chk_en = 1'b0;
    i_loop_len = 4'd5;
    i_mode = 1'b1;
    step();
    check_eq("flush_vld", 32'(o_rd_valid), 32'd0);
    check_eq("flush_state", 32'(o_dbg_state), 32'd2);
    check_eq("loop_wr_rdy", 32'(o_wr_ready), 32'd0);
    repeat (6) step();
    chk_en = 1'b1;
    loop_flag = 1'b1;
    for (int i = 0; i < 12; i++) exp_q.push_back(loop_vals[i % 5]);
    i_rd_ready = 1'b1;
    wait_drain("drain_loop");
    i_rd_ready = 1'b0;
    check_eq("loop_cnt", 32'(o_count), 32'd6);
    check_eq("loop_wr_rdy2", 32'(o_wr_ready), 32'd0);
    chk_en = 1'b0;
    i_mode = 1'b0;
    step();
    check_eq("flush2_vld", 32'(o_rd_valid), 32'd0);
    repeat (6) step();
    check_eq("resume_cnt", 32'(o_count), 32'd6);
    chk_en = 1'b1;
    loop_flag = 1'b0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'hA0 + 32'(i));
    i_rd_ready = 1'b1;
    wait_drain("drain_resume");
    check_eq("resume_empty", 32'(o_count), 32'd0);

    // LOOP with zero length issues nothing
    chk_en = 1'b0;
    i_loop_len = '0;
    i_mode = 1'b1;
    repeat (10) step();
    check_eq("len0_vld", 32'(o_rd_valid), 32'd0);
    check_eq("len0_state", 32'(o_dbg_state), 32'd1);
    i_mode = 1'b0;
    repeat (3) step();

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/info_stream_buffer.md
# info_stream_buffer

Parametrised message buffer between the message source and the QPSK symbol mapper in the TX chain. It stores data words in a simple-dual-port block RAM and presents them on a valid/ready read stream.
- FIFO mode: words are consumed once.
- LOOP mode: a stored message of programmable length is replayed cyclically, as used for PRBS test transmissions.
- RAM read latency is selectable. A prefetch queue hides that latency and supports backpressure.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_EXP, 10, log2 of RAM depth; DEPTH = 2**ADDR_EXP
- OUT_REG, 1, 0: RAM read latency 1 cycle; 1: extra output register, latency 2 cycles
- clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_mode  in  1  0 = FIFO, 1 = LOOP
- i_loop_len  in  ADDR_EXP+1  number of words replayed in LOOP mode (0..DEPTH)
- i_wr_valid  in  1  write word present
- i_wr_data  in  DATA_WIDTH  write word
- o_wr_ready  out  1  write accepted when high with i_wr_valid
- o_rd_valid  out  1  o_rd_data valid
- o_rd_data  out  DATA_WIDTH  read word
- i_rd_ready  in  1  consumer accepts word
- o_count  out  ADDR_EXP+1  FIFO occupancy, including words in flight and queued
- o_full  out  1  o_count == DEPTH
- o_empty  out  1  o_count == 0
- o_wrap  out  1  one-cycle pulse when LOOP index wraps to 0

## Operation
- Reset values: wr_ptr = rd_ptr = loop_idx = 0, queue empty, o_count = 0, o_empty = 1, o_full = 0, o_rd_valid = 0, o_rd_data = 0, o_wrap = 0. The mode register resets to FIFO.
- RAM contents are not cleared by reset.
- Handshakes:
  - A write is accepted on an edge with i_wr_valid & o_wr_ready.
  - A read transfer happens on an edge with o_rd_valid & i_rd_ready.
  - o_rd_data/o_rd_valid stay stable while i_rd_ready is low.
- FIFO mode:
  - o_wr_ready = !o_full.
  - An accepted write stores to RAM[wr_ptr]; wr_ptr increments modulo DEPTH.
  - o_count increments on accept and decrements on read transfer; both in the same cycle leaves it unchanged.
  - A read is issued from RAM[rd_ptr] when rd_ptr != wr_ptr (unissued words exist) and in-flight + queued < QDEPTH, where QDEPTH = OUT_REG+2. rd_ptr increments modulo DEPTH.
- LOOP mode:
  - o_wr_ready = 0; FIFO pointers and o_count are frozen.
  - Reads are issued from RAM[loop_idx] under the same queue-credit rule.
  - loop_idx increments and wraps to 0 after loop_len-1.
  - o_wrap pulses in the cycle the word at index loop_len-1 is transferred.
  - loop_len is latched on entry to LOOP mode. If loop_len == 0, no reads are issued and o_rd_valid stays 0.
  - Words are never consumed.
- Mode change is detected as i_mode differing from the mode register. On the next edge:
  - the queue and in-flight reads are flushed and o_rd_valid drops for at least 1 cycle;
  - loop_idx is set to 0;
  - in FIFO mode, rd_ptr is rewound by the number of flushed, unconsumed words, so no FIFO data is lost.
- States: RUN_FIFO, RUN_LOOP, FLUSH (one cycle, between any mode change and the new RUN state).
- Wrap-around: pointers are ADDR_EXP bits and wrap naturally. Full vs empty is distinguished by o_count, not by pointer compare.

## Timing
- Write accepted at edge t → o_rd_valid high from edge t+2+OUT_REG if the queue was empty and the consumer is idle.
- With i_rd_ready held high and data available, sustained throughput is 1 word per cycle, with no bubbles after the first word.
- Backpressure: with i_rd_ready low, at most QDEPTH words are outstanding. No data is dropped or duplicated.
- Full boundary: a simultaneous read transfer while full does not raise o_wr_ready in that cycle. It rises the following cycle (registered from o_count).
- Reset mid-stream: the next edge returns all outputs to reset values, and prior writes become unreachable (pointers zeroed).
- In LOOP mode, first o_rd_valid occurs 2+OUT_REG cycles after FLUSH.

## Test plan
- FIFO, OUT_REG=1: write 0x1..0x8 back-to-back, i_rd_ready=1 → o_rd_data 0x1..0x8 in order, first valid 3 cycles after first write, 8 consecutive valid cycles.
- Full/wrap: ADDR_EXP=3, write 8 words → o_full=1, o_wr_ready=0. Read 3, write 3 more → pointers wrap, data order preserved, o_count returns to 8.
- Backpressure: toggle i_rd_ready pseudo-randomly over 100 words → scoreboard matches exactly; o_rd_data stable while stalled.
- LOOP: load 0xA0..0xA4, set i_loop_len=5, i_mode=1, i_rd_ready=1 → stream A0,A1,A2,A3,A4,A0,…; o_wrap pulses with every A4; o_wr_ready=0.
- Mode switch mid-stall: FIFO with 6 words and 3 queued unconsumed; switch to LOOP then back → FIFO resumes at the first unconsumed word, no loss, o_count=6.
- Reset asserted during streaming → next cycle o_rd_valid=0, o_count=0, o_empty=1, o_rd_data=0.
